// File: rtl/led_pkg.sv
// Shared types and reset defaults for the multi-channel LED pattern generator.
package led_pkg;

    // Per-channel operating mode; encoding matches the cfg_mode write field.
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

    // Channel state after reset: blinking, starting from the dark phase.
    localparam led_mode_t RST_MODE    = MODE_BLINK;
    localparam logic      RST_BLINK_Q = 1'b0;
    localparam logic      RST_DIR_UP  = 1'b1;

    // Channel state after a valid configuration write: lit phase first, ramp up from dark.
    localparam logic      LOAD_BLINK_Q = 1'b1;
    localparam logic      LOAD_DIR_UP  = 1'b1;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/period, steps its phase on ticks and drives a registered LED bit.
module led_channel
    import led_pkg::*;
#(
    parameter int PERIOD_W            = 16,
    parameter int PWM_W               = 8,
    parameter int DEFAULT_HALF_PERIOD = 500
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [PWM_W-1:0]    pwm_cnt,
    input  logic                we,
    input  led_mode_t           mode,
    input  logic [PERIOD_W-1:0] period,
    output logic                led
);

    localparam logic [PWM_W-1:0]    DUTY_MAX = '1;
    localparam logic [PWM_W-1:0]    DUTY_ONE = PWM_W'(1);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

    led_mode_t           mode_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt;
    logic                blink_q;
    logic [PWM_W-1:0]    duty;
    logic                dir_up;
    logic                phase_wrap;
    logic                animated;

    // The phase counter wraps after period_q ticks; only BLINK and BREATHE consume ticks.
    assign phase_wrap = (cnt == period_q - CNT_ONE);
    assign animated   = (mode_q == MODE_BLINK) || (mode_q == MODE_BREATHE);

    // Channel state: a write reloads everything and takes priority over a coincident tick.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode_q   <= RST_MODE;
            period_q <= PERIOD_W'(DEFAULT_HALF_PERIOD);
            cnt      <= '0;
            blink_q  <= RST_BLINK_Q;
            duty     <= '0;
            dir_up   <= RST_DIR_UP;
        end else if (we) begin
            mode_q   <= mode;
            period_q <= period;
            cnt      <= '0;
            blink_q  <= LOAD_BLINK_Q;
            duty     <= '0;
            dir_up   <= LOAD_DIR_UP;
        end else if (tick && animated) begin
            if (!phase_wrap) begin
                cnt <= cnt + CNT_ONE;
            end else begin
                cnt <= '0;
                if (mode_q == MODE_BLINK) begin
                    blink_q <= ~blink_q;
                end else if (dir_up) begin
                    // Top of the ramp reflects straight to MAX-1 so MAX is held for one step only.
                    if (duty == DUTY_MAX) begin
                        dir_up <= 1'b0;
                        duty   <= DUTY_MAX - DUTY_ONE;
                    end else begin
                        duty <= duty + DUTY_ONE;
                    end
                end else begin
                    if (duty == '0) begin
                        dir_up <= 1'b1;
                        duty   <= DUTY_ONE;
                    end else begin
                        duty <= duty - DUTY_ONE;
                    end
                end
            end
        end
    end

    // Registered LED drive decoded from the current channel state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            case (mode_q)
                MODE_OFF:     led <= 1'b0;
                MODE_ON:      led <= 1'b1;
                MODE_BLINK:   led <= blink_q;
                MODE_BREATHE: led <= (pwm_cnt < duty);
                default:      led <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter, write decode, channels.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CH_NUM              = 4,
    parameter int TICK_DIV            = 200000,
    parameter int PERIOD_W            = 16,
    parameter int PWM_W               = 8,
    parameter int DEFAULT_HALF_PERIOD = 500,
    parameter int CH_W                = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [CH_NUM-1:0]   led,
    output logic                cfg_err
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CH_NUM);

    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              wr_ok;
    logic [CH_NUM-1:0] ch_we;

    assign tick  = (pre_cnt == PRE_LAST);
    // The extra MSB keeps the range check meaningful when CH_NUM is a power of two.
    assign wr_ok = ({1'b0, cfg_ch} < CH_LIMIT) && (cfg_period != '0);

    // Tick prescaler: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge sys_clk) begin
        if (rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Free-running PWM frame counter shared by every channel.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // One-cycle error pulse for a write that targets a missing channel or carries a zero period.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !wr_ok;
        end
    end

    // Decode the accepted write into a per-channel strobe.
    // NOTE: the default is assigned first so no latch is inferred for unselected channels.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (cfg_we && wr_ok && (cfg_ch == CH_W'(i))) begin
                ch_we[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        led_channel #(
            .PERIOD_W            (PERIOD_W),
            .PWM_W               (PWM_W),
            .DEFAULT_HALF_PERIOD (DEFAULT_HALF_PERIOD)
        ) u_channel (
            .sys_clk (sys_clk),
            .rst     (rst),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .we      (ch_we[g]),
            .mode    (led_mode_t'(cfg_mode)),
            .period  (cfg_period),
            .led     (led[g])
        );
    end

endmodule
